hmr_recovery_halt_responder: RTL

// Core-side responder to the HMR rapid-recovery halt/resume handshake. It sits between the

---
 rtl/hmr_recovery_halt_responder_if.sv | 38 +++
 rtl/hmr_recovery_halt_responder.sv | 126 ++++++++++++
 2 files changed

// File: rtl/hmr_recovery_halt_responder_if.sv
// Signal bundle between the recovery controller, the core and its instr/data OBI ports.
// The responder uses the slave view; the surrounding environment uses the master view.
interface hmr_recovery_halt_responder_if;
  logic instr_lock_i;
  logic debug_req_i;
  logic debug_resume_i;
  logic debug_halt_o;
  logic core_debug_req_o;
  logic core_debug_mode_i;
  logic core_resume_o;
  logic instr_req_i;
  logic instr_gnt_o;
  logic instr_req_o;
  logic instr_gnt_i;
  logic instr_rvalid_i;
  logic data_req_i;
  logic data_gnt_o;
  logic data_req_o;
  logic data_gnt_i;
  logic data_rvalid_i;
  logic error_o;

  modport slave (
    input  instr_lock_i, debug_req_i, debug_resume_i, core_debug_mode_i,
    input  instr_req_i, instr_gnt_i, instr_rvalid_i,
    input  data_req_i, data_gnt_i, data_rvalid_i,
    output debug_halt_o, core_debug_req_o, core_resume_o,
    output instr_gnt_o, instr_req_o, data_gnt_o, data_req_o, error_o
  );

  modport master (
    output instr_lock_i, debug_req_i, debug_resume_i, core_debug_mode_i,
    output instr_req_i, instr_gnt_i, instr_rvalid_i,
    output data_req_i, data_gnt_i, data_rvalid_i,
    input  debug_halt_o, core_debug_req_o, core_resume_o,
    input  instr_gnt_o, instr_req_o, data_gnt_o, data_req_o, error_o
  );
endinterface

// File: rtl/hmr_recovery_halt_responder.sv
// Core-side responder for the HMR halt/resume handshake: gates OBI requests, tracks
// outstanding transactions and acknowledges a halt only once the core is halted and drained.
module hmr_recovery_halt_responder #(
  parameter int unsigned MaxOutstanding = 4
) (
  input logic                          clk_i,
  input logic                          rst_ni,
  hmr_recovery_halt_responder_if.slave bus
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2,
    RESUME = 2'd3
  } state_e;

  state_e              state;
  logic [CntWidth-1:0] icnt;
  logic [CntWidth-1:0] dcnt;
  logic                core_debug_req_q;
  logic                debug_halt_q;
  logic                core_resume_q;
  logic                error_q;

  logic instr_fire;
  logic data_fire;
  logic drain_done;
  logic error_event;

  assign bus.instr_req_o = bus.instr_req_i & ~bus.instr_lock_i & (icnt != CntMax);
  assign bus.instr_gnt_o = bus.instr_gnt_i & bus.instr_req_o;
  assign bus.data_req_o  = bus.data_req_i & (dcnt != CntMax);
  assign bus.data_gnt_o  = bus.data_gnt_i & bus.data_req_o;

  assign instr_fire = bus.instr_req_o & bus.instr_gnt_i;
  assign data_fire  = bus.data_req_o & bus.data_gnt_i;

  // A grant landing in the same cycle would open a new transaction, so it blocks the halt ack.
  assign drain_done = bus.core_debug_mode_i & (icnt == '0) & (dcnt == '0)
                    & ~instr_fire & ~data_fire;

  assign error_event = (bus.instr_rvalid_i & (icnt == '0))
                     | (bus.data_rvalid_i & (dcnt == '0))
                     | (bus.debug_resume_i & (state != HALTED));

  assign bus.core_debug_req_o = core_debug_req_q;
  assign bus.debug_halt_o     = debug_halt_q;
  assign bus.core_resume_o    = core_resume_q;
  assign bus.error_o          = error_q;

  // A simultaneous grant and response cancel out; a stray response never underflows.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      icnt <= '0;
      dcnt <= '0;
    end else begin
      if (instr_fire && !bus.instr_rvalid_i) begin
        icnt <= icnt + CntWidth'(1);
      end else if (bus.instr_rvalid_i && !instr_fire && (icnt != '0)) begin
        icnt <= icnt - CntWidth'(1);
      end
      if (data_fire && !bus.data_rvalid_i) begin
        dcnt <= dcnt + CntWidth'(1);
      end else if (bus.data_rvalid_i && !data_fire && (dcnt != '0)) begin
        dcnt <= dcnt - CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      error_q <= 1'b0;
    end else if (error_event) begin
      error_q <= 1'b1;
    end
  end

  // Outputs are loaded on the transition so each one appears the cycle after its trigger.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state            <= RUN;
      core_debug_req_q <= 1'b0;
      debug_halt_q     <= 1'b0;
      core_resume_q    <= 1'b0;
    end else begin
      core_resume_q <= 1'b0;
      case (state)
        RUN: begin
          if (bus.debug_req_i) begin
            state            <= DRAIN;
            core_debug_req_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state        <= HALTED;
            debug_halt_q <= 1'b1;
          end
        end
        HALTED: begin
          if (bus.debug_resume_i) begin
            state            <= RESUME;
            debug_halt_q     <= 1'b0;
            core_debug_req_q <= 1'b0;
            core_resume_q    <= 1'b1;
          end
        end
        RESUME: begin
          if (!bus.core_debug_mode_i) begin
            state <= RUN;
          end
        end
        default: begin
          state            <= RUN;
          core_debug_req_q <= 1'b0;
          debug_halt_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule
